ws2812_frame_ctrl: RTL and testbench

Frame scheduler and pixel source for the ws2812 serial LED driver.
- Holds a double-buffered pixel store, NUM_LEDS x 24 bit per bank, written by the host (SPI-side) logic.
- Kicks the driver on host command or on a periodic refresh timer, and serves the driver's per-LED colour reads with global brightness scaling applied.
- Bank swaps occur only between frames, so the chain never shows a torn frame.

---
 rtl/ws2812_pkg.sv | 29 ++
 rtl/ws2812_pixel_ram.sv | 29 ++
 rtl/ws2812_frame_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_ws2812_frame_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared definitions for the ws2812 frame controller: FSM states, pixel
// layout and the brightness scaling helper.
package ws2812_pkg;

  localparam int PIXEL_W = 24;

  // Colour byte positions inside a stored pixel: {green, red, blue}.
  localparam int G_MSB = 23;
  localparam int G_LSB = 16;
  localparam int R_MSB = 15;
  localparam int R_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KICK = 2'd1,
    WAIT = 2'd2,
    RUN  = 2'd3
  } state_t;

  // (c * (br + 1)) >> 8 : br = 255 passes c through unchanged, br = 0 gives 0.
  function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] br);
    logic [15:0] prod;
    prod = 16'(c) * (16'(br) + 16'd1);
    return prod[15:8];
  endfunction

endpackage

// File: rtl/ws2812_pixel_ram.sv
// Simple dual-port pixel store holding both banks. The bank select is the
// address MSB; the read port is registered.
module ws2812_pixel_ram
  import ws2812_pkg::*;
#(
  parameter int AW = 3
) (
  input  logic               clk_i,
  input  logic               wr_en_i,
  input  logic [AW:0]        wr_addr_i,
  input  logic [PIXEL_W-1:0] wr_data_i,
  input  logic [AW:0]        rd_addr_i,
  output logic [PIXEL_W-1:0] rd_data_o
);

  // Sized to the full {bank, index} space so every address is in range.
  logic [PIXEL_W-1:0] mem [2**(AW+1)];

  // Write port and registered read port.
  // NOTE: the storage array and its read register have no reset; clearing a
  // RAM needs a sequencer, and the first frame is written by the host anyway.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
    rd_data_o <= mem[rd_addr_i];
  end

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// Frame scheduler and pixel source for the ws2812 serial LED driver.
// Double-buffered pixel store, show/auto-refresh kicking, brightness scaling.
module ws2812_frame_ctrl
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS       = 8,
  parameter int REFRESH_CYCLES = 1_000_000,
  parameter int START_TIMEOUT  = 8192,
  parameter int AW             = $clog2(NUM_LEDS)
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               wr_en_i,
  input  logic [AW-1:0]      wr_addr_i,
  input  logic [PIXEL_W-1:0] wr_data_i,
  input  logic               show_i,
  input  logic               auto_en_i,
  input  logic [7:0]         brightness_i,
  input  logic [AW-1:0]      led_count_i,
  output logic               drv_start_o,
  input  logic               drv_busy_i,
  input  logic [AW-1:0]      drv_address_i,
  output logic [7:0]         drv_red_o,
  output logic [7:0]         drv_green_o,
  output logic [7:0]         drv_blue_o,
  output logic [AW-1:0]      drv_led_count_o,
  output logic               busy_o,
  output logic               swap_pending_o,
  output logic               frame_done_o,
  output logic               timeout_o
);

  localparam int TW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int WW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [TW-1:0] REFRESH_LAST = TW'(REFRESH_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST    = WW'(START_TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                front_bank_q;
  logic                swap_pending_q;
  logic [TW-1:0]       refresh_cnt_q;
  logic [WW-1:0]       wait_cnt_q;
  logic                timeout_q;
  logic                frame_done_q;
  logic [AW-1:0]       led_count_q;

  logic                take_swap;
  logic                kick;
  logic                refresh_inc;
  logic                wait_inc;
  logic                start_ok;
  logic                start_fail;
  logic                run_done;

  logic                wr_ok;
  logic [PIXEL_W-1:0]  rd_pixel;

  // State register.
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update together from pre-edge values, independent of block order.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    take_swap   = 1'b0;
    kick        = 1'b0;
    refresh_inc = 1'b0;
    wait_inc    = 1'b0;
    start_ok    = 1'b0;
    start_fail  = 1'b0;
    run_done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A pending swap wins over a refresh expiry; one kick serves both.
        if (swap_pending_q) begin
          take_swap = 1'b1;
          state_d   = KICK;
        end else if (auto_en_i) begin
          if (refresh_cnt_q == REFRESH_LAST) begin
            state_d = KICK;
          end else begin
            refresh_inc = 1'b1;
          end
        end
      end
      KICK: begin
        kick    = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (drv_busy_i) begin
          start_ok = 1'b1;
          state_d  = RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          start_fail = 1'b1;
          state_d    = IDLE;
        end else begin
          wait_inc = 1'b1;
        end
      end
      RUN: begin
        if (!drv_busy_i) begin
          run_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bank select, swap request, timers and sticky/pulsed status.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      front_bank_q   <= 1'b0;
      swap_pending_q <= 1'b0;
      refresh_cnt_q  <= '0;
      wait_cnt_q     <= '0;
      timeout_q      <= 1'b0;
      frame_done_q   <= 1'b0;
      led_count_q    <= '0;
    end else begin
      // A new show_i beats the clear, so it stays pending for the next frame.
      if (show_i) begin
        swap_pending_q <= 1'b1;
      end else if (take_swap) begin
        swap_pending_q <= 1'b0;
      end

      if (take_swap) begin
        front_bank_q <= ~front_bank_q;
      end

      if (kick) begin
        refresh_cnt_q <= '0;
      end else if (refresh_inc) begin
        refresh_cnt_q <= refresh_cnt_q + TW'(1);
      end

      if (kick) begin
        wait_cnt_q  <= '0;
        led_count_q <= led_count_i;
      end else if (wait_inc) begin
        wait_cnt_q <= wait_cnt_q + WW'(1);
      end

      if (start_fail) begin
        timeout_q <= 1'b1;
      end else if (start_ok) begin
        timeout_q <= 1'b0;
      end

      frame_done_q <= run_done;
    end
  end

  // Indices past the end of the chain are dropped rather than aliased.
  assign wr_ok = wr_en_i && (int'(wr_addr_i) < NUM_LEDS);

  ws2812_pixel_ram #(
    .AW (AW)
  ) u_ram (
    .clk_i     (clk_i),
    .wr_en_i   (wr_ok),
    .wr_addr_i ({~front_bank_q, wr_addr_i}),
    .wr_data_i (wr_data_i),
    .rd_addr_i ({front_bank_q, drv_address_i}),
    .rd_data_o (rd_pixel)
  );

  // Second pixel stage: brightness scaling, registered.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      drv_green_o <= '0;
      drv_red_o   <= '0;
      drv_blue_o  <= '0;
    end else begin
      drv_green_o <= scale8(rd_pixel[G_MSB:G_LSB], brightness_i);
      drv_red_o   <= scale8(rd_pixel[R_MSB:R_LSB], brightness_i);
      drv_blue_o  <= scale8(rd_pixel[B_MSB:B_LSB], brightness_i);
    end
  end

  assign drv_start_o     = (state_q == KICK);
  assign drv_led_count_o = led_count_q;
  assign busy_o          = (state_q != IDLE);
  assign swap_pending_o  = swap_pending_q;
  assign frame_done_o    = frame_done_q;
  assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Self-checking bench for ws2812_frame_ctrl: table of pixel/brightness
// vectors plus directed sequences for swap, refresh, timeout and reset.
module tb_ws2812_frame_ctrl;

  localparam int NUM_LEDS = 6;
  localparam int AW       = 3;
  localparam int REFRESH  = 100;
  localparam int START_TO = 64;

  logic          clk_i;
  logic          reset_ni;
  logic          wr_en_i;
  logic [AW-1:0] wr_addr_i;
  logic [23:0]   wr_data_i;
  logic          show_i;
  logic          auto_en_i;
  logic [7:0]    brightness_i;
  logic [AW-1:0] led_count_i;
  logic          drv_start_o;
  logic          drv_busy_i;
  logic [AW-1:0] drv_address_i;
  logic [7:0]    drv_red_o;
  logic [7:0]    drv_green_o;
  logic [7:0]    drv_blue_o;
  logic [AW-1:0] drv_led_count_o;
  logic          busy_o;
  logic          swap_pending_o;
  logic          frame_done_o;
  logic          timeout_o;

  int  n_vec;
  int  n_err;
  int  busy_len;
  int  busy_left;
  bit  model_en;
  bit  model_kill;

  // Expected contents of both banks and which one is in front.
  logic [23:0] bank_model [2][NUM_LEDS];
  logic        front_model;

  typedef struct {
    logic [23:0] pix;
    logic [7:0]  br;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs [8];

  ws2812_frame_ctrl #(
    .NUM_LEDS       (NUM_LEDS),
    .REFRESH_CYCLES (REFRESH),
    .START_TIMEOUT  (START_TO)
  ) dut (
    .clk_i           (clk_i),
    .reset_ni        (reset_ni),
    .wr_en_i         (wr_en_i),
    .wr_addr_i       (wr_addr_i),
    .wr_data_i       (wr_data_i),
    .show_i          (show_i),
    .auto_en_i       (auto_en_i),
    .brightness_i    (brightness_i),
    .led_count_i     (led_count_i),
    .drv_start_o     (drv_start_o),
    .drv_busy_i      (drv_busy_i),
    .drv_address_i   (drv_address_i),
    .drv_red_o       (drv_red_o),
    .drv_green_o     (drv_green_o),
    .drv_blue_o      (drv_blue_o),
    .drv_led_count_o (drv_led_count_o),
    .busy_o          (busy_o),
    .swap_pending_o  (swap_pending_o),
    .frame_done_o    (frame_done_o),
    .timeout_o       (timeout_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Driver model: busy rises on the kick and stays up for busy_len cycles.
  initial begin
    drv_busy_i = 1'b0;
    busy_left  = 0;
    forever begin
      @(negedge clk_i);
      if (model_kill) begin
        drv_busy_i = 1'b0;
        busy_left  = 0;
      end else if (drv_start_o && model_en) begin
        drv_busy_i = 1'b1;
        busy_left  = busy_len;
      end else if (busy_left > 0) begin
        busy_left = busy_left - 1;
        if (busy_left == 0) drv_busy_i = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] pix_out();
    return {8'h00, drv_green_o, drv_red_o, drv_blue_o};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [23:0] d);
    wr_en_i   = 1'b1;
    wr_addr_i = a;
    wr_data_i = d;
    @(negedge clk_i);
    wr_en_i = 1'b0;
    if (int'(a) < NUM_LEDS) bank_model[!front_model][a] = d;
  endtask

  task automatic pulse_show();
    show_i = 1'b1;
    @(negedge clk_i);
    show_i = 1'b0;
  endtask

  task automatic wait_start(input string name, input int limit, output int n);
    n = 0;
    while (drv_start_o !== 1'b1 && n < limit) begin
      @(negedge clk_i);
      n++;
    end
    check({name, "_start_seen"}, 32'(drv_start_o), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while (busy_o !== 1'b0 && n < limit) begin
      @(negedge clk_i);
      n++;
    end
    check({name, "_idle_seen"}, 32'(busy_o), 32'd0);
  endtask

  task automatic count_starts(input int cycles, output int k);
    k = 0;
    repeat (cycles) begin
      @(negedge clk_i);
      if (drv_start_o === 1'b1) k++;
    end
  endtask

  initial begin
    int  n;
    int  k;
    bit  pend_ok;

    n_vec = 0;
    n_err = 0;

    // pixel, brightness, expected {G,R,B} = (c * (br+1)) >> 8 per byte
    vecs[0] = '{24'h112233, 8'hFF, 24'h112233};
    vecs[1] = '{24'hFF8001, 8'h7F, 24'h7F4000};
    vecs[2] = '{24'hFF8001, 8'h00, 24'h000000};
    vecs[3] = '{24'hFFFFFF, 8'hFF, 24'hFFFFFF};
    vecs[4] = '{24'h80C040, 8'h3F, 24'h203010};
    vecs[5] = '{24'h0A0B0C, 8'hC8, 24'h070809};
    vecs[6] = '{24'hFFFFFF, 8'h00, 24'h000000};
    vecs[7] = '{24'hFF0180, 8'h01, 24'h010001};

    reset_ni      = 1'b0;
    wr_en_i       = 1'b0;
    wr_addr_i     = '0;
    wr_data_i     = '0;
    show_i        = 1'b0;
    auto_en_i     = 1'b0;
    brightness_i  = 8'hFF;
    led_count_i   = 3'd6;
    drv_address_i = '0;
    model_en      = 1'b1;
    model_kill    = 1'b0;
    busy_len      = 8;
    front_model   = 1'b0;

    // ---- reset state ----
    step(3);
    check("rst_busy",       32'(busy_o),          32'd0);
    check("rst_start",      32'(drv_start_o),     32'd0);
    check("rst_pending",    32'(swap_pending_o),  32'd0);
    check("rst_done",       32'(frame_done_o),    32'd0);
    check("rst_timeout",    32'(timeout_o),       32'd0);
    check("rst_led_count",  32'(drv_led_count_o), 32'd0);
    check("rst_pixel",      pix_out(),            32'd0);
    reset_ni = 1'b1;
    step(2);

    // ---- 1: first show, kick timing, pixel, frame done ----
    host_write(3'd0, 24'h112233);
    show_i = 1'b1;
    @(negedge clk_i);
    show_i = 1'b0;
    check("t1_pending_set",  32'(swap_pending_o), 32'd1);
    check("t1_no_early_start", 32'(drv_start_o), 32'd0);
    @(negedge clk_i);
    front_model = ~front_model;
    check("t1_start_2cyc",   32'(drv_start_o),    32'd1);
    check("t1_pending_clr",  32'(swap_pending_o), 32'd0);
    @(negedge clk_i);
    check("t1_start_1cyc",   32'(drv_start_o),    32'd0);
    check("t1_led_count",    32'(drv_led_count_o), 32'd6);
    led_count_i = 3'd3;
    @(negedge clk_i);
    check("t1_pixel",        pix_out(),           32'h00112233);
    wait_idle("t1", 100);
    check("t1_frame_done",   32'(frame_done_o),   32'd1);
    check("t1_led_count_held", 32'(drv_led_count_o), 32'd6);
    @(negedge clk_i);
    check("t1_frame_done_1cyc", 32'(frame_done_o), 32'd0);
    led_count_i = 3'd5;

    // ---- 2: brightness scaling table ----
    busy_len = 4;
    for (int i = 0; i < 8; i++) begin
      host_write(3'd0, vecs[i].pix);
      pulse_show();
      front_model = ~front_model;
      wait_start($sformatf("vec%0d", i), 20, n);
      wait_idle($sformatf("vec%0d", i), 50);
      brightness_i = vecs[i].br;
      step(3);
      check($sformatf("vec%0d_pixel", i), pix_out(), {8'h00, vecs[i].exp});
    end

    // read latency: address change shows up exactly two cycles later
    brightness_i = 8'hFF;
    host_write(3'd1, 24'hA0B0C0);
    host_write(3'd0, 24'h010203);
    pulse_show();
    front_model = ~front_model;
    wait_start("lat", 20, n);
    wait_idle("lat", 50);
    drv_address_i = 3'd1;
    step(3);
    check("lat_addr1", pix_out(), {8'h00, bank_model[front_model][1]});
    drv_address_i = 3'd0;
    step(1);
    check("lat_old_1cyc", pix_out(), 32'h00A0B0C0);
    step(1);
    check("lat_new_2cyc", pix_out(), 32'h00010203);

    // write past the chain end is dropped
    host_write(3'd6, 24'hDEAD99);
    pulse_show();
    front_model = ~front_model;
    wait_start("oob", 20, n);
    wait_idle("oob", 50);
    drv_address_i = 3'd6;
    step(3);
    check("oob_write_dropped", 32'(pix_out() !== 32'h00DEAD99), 32'd1);
    drv_address_i = 3'd0;
    step(3);
    check("oob_addr0_intact", pix_out(), {8'h00, bank_model[front_model][0]});

    // ---- 3: repeated show during RUN coalesces into one swap ----
    busy_len = 30;
    pulse_show();
    front_model = ~front_model;
    wait_start("t3a", 20, n);
    step(2);
    check("t3_in_run", 32'(busy_o && drv_busy_i), 32'd1);
    host_write(3'd0, 24'h5A5A5A);
    pend_ok = 1'b1;
    for (int p = 0; p < 3; p++) begin
      pulse_show();
      step(1);
      pend_ok = pend_ok && (swap_pending_o === 1'b1);
    end
    n = 0;
    while (busy_o === 1'b1 && n < 100) begin
      pend_ok = pend_ok && (swap_pending_o === 1'b1);
      step(1);
      n++;
    end
    check("t3_pending_held", 32'(pend_ok), 32'd1);
    check("t3_run_ended", 32'(busy_o), 32'd0);
    count_starts(120, k);
    front_model = ~front_model;
    check("t3_one_kick", 32'(k), 32'd1);
    check("t3_pending_clr", 32'(swap_pending_o), 32'd0);
    check("t3_one_toggle", pix_out(), 32'h005A5A5A);

    // ---- 4: periodic refresh ----
    busy_len  = 50;
    auto_en_i = 1'b1;
    wait_start("t4_first", 300, n);
    check("t4_first_latency", 32'(n), 32'(REFRESH));
    for (int r = 0; r < 2; r++) begin
      step(1);
      wait_start($sformatf("t4_per%0d", r), 400, n);
      // idle REFRESH cycles + KICK + WAIT + (busy_len-1) RUN cycles
      check($sformatf("t4_period%0d", r), 32'(n + 1), 32'(REFRESH + busy_len + 1));
    end
    check("t4_bank_same", pix_out(), {8'h00, bank_model[front_model][0]});
    check("t4_no_pending", 32'(swap_pending_o), 32'd0);
    auto_en_i = 1'b0;
    wait_idle("t4", 100);

    // ---- 5: start timeout, then recovery ----
    model_en = 1'b0;
    pulse_show();
    front_model = ~front_model;
    wait_start("t5", 20, n);
    n = 0;
    while (timeout_o !== 1'b1 && n < 4 * START_TO) begin
      step(1);
      n++;
    end
    check("t5_timeout_latency", 32'(n), 32'(START_TO + 1));
    check("t5_back_idle", 32'(busy_o), 32'd0);
    step(5);
    check("t5_timeout_sticky", 32'(timeout_o), 32'd1);
    model_en = 1'b1;
    busy_len = 10;
    pulse_show();
    front_model = ~front_model;
    wait_start("t5b", 20, n);
    check("t5_sticky_until_start", 32'(timeout_o), 32'd1);
    step(3);
    check("t5_cleared", 32'(timeout_o), 32'd0);
    check("t5_running", 32'(busy_o), 32'd1);
    wait_idle("t5b", 50);

    // ---- 6: asynchronous reset mid-frame with a swap pending ----
    busy_len = 40;
    host_write(3'd0, 24'h0F1E2D);
    pulse_show();
    front_model = ~front_model;
    wait_start("t6", 20, n);
    host_write(3'd0, 24'h654321);
    step(4);
    pulse_show();
    check("t6_pending_before", 32'(swap_pending_o), 32'd1);
    step(2);
    #2;
    reset_ni   = 1'b0;
    model_kill = 1'b1;
    #1;
    check("t6_busy",       32'(busy_o),          32'd0);
    check("t6_pending",    32'(swap_pending_o),  32'd0);
    check("t6_start",      32'(drv_start_o),     32'd0);
    check("t6_timeout",    32'(timeout_o),       32'd0);
    check("t6_led_count",  32'(drv_led_count_o), 32'd0);
    check("t6_pixel",      pix_out(),            32'd0);
    front_model = 1'b0;
    step(2);
    reset_ni   = 1'b1;
    model_kill = 1'b0;
    step(3);
    check("t6_front_bank0", pix_out(), {8'h00, bank_model[0][0]});
    count_starts(20, k);
    check("t6_swap_dropped", 32'(k), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
